// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the RV32I datapath (master) and the data-memory
// responder (slave).
interface dmem_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemBusyM;
    logic        MisalignM;

    modport master (
        output MemReqM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        input  ReadDataM, MemBusyM, MisalignM
    );

    modport slave (
        input  MemReqM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        output ReadDataM, MemBusyM, MisalignM
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM for the pipelined RV32I core. It inserts WAIT_CYCLES
// wait states per access and stalls the pipeline through MemBusyM until done.
module dmem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES - 1);
    localparam logic       ZERO_WAIT = 1'(WAIT_CYCLES == 0);

    // H/HU need an even offset, W a zero offset; BU/HU have no store form.
    function automatic logic misaligned_f(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = 4'b0011 << off;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the datum across lanes lets the byte enables pick the target lane.
    function automatic logic [31:0] store_lanes_f(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            3'b000:  lanes = {4{wd[7:0]}};
            3'b001:  lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [31:0] word,
                                               input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = sh;
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0] mem_q [0:(1 << AW) - 1];
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        access_s;
    logic        mis_s;
    logic        wr_en_s;
    logic [3:0]  be_s;
    logic [31:0] wlanes_s;
    logic [31:0] rd_word_s;
    logic [AW-1:0] word_idx_s;
    logic [1:0]  off_s;
    logic        unused_addr_s;

    // Upper address bits are ignored, so the RAM aliases across the 32-bit space.
    assign word_idx_s    = bus.ALUResultM[AW+1:2];
    assign off_s         = bus.ALUResultM[1:0];
    assign unused_addr_s = ^bus.ALUResultM[31:AW+2];

    assign mis_s     = misaligned_f(bus.MemWriteM, bus.funct3M, off_s);
    assign be_s      = byte_en_f(bus.funct3M, off_s);
    assign wlanes_s  = store_lanes_f(bus.funct3M, bus.WriteDataM);
    assign rd_word_s = mem_q[word_idx_s];
    assign wr_en_s   = access_s & bus.MemWriteM & ~mis_s;

    // Access sequencing: IDLE -> WAIT (countdown) -> DONE, flushed by a dropped request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.MemReqM) begin
                    if (ZERO_WAIT) begin
                        access_s = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.MemReqM) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    access_s = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result and misalignment flag change only at the edge that performs the access.
    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (access_s) begin
            mis_d = mis_s;
            if (!bus.MemWriteM) begin
                rdata_d = mis_s ? 32'h0000_0000 : load_ext_f(bus.funct3M, rd_word_s, off_s);
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            mis_d = mis_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // RAM array keeps its contents through reset; a reset cancels any pending write.
    always_ff @(posedge clk) begin
        if (reset && wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.ReadDataM = rdata_q;
    assign bus.MisalignM = mis_q;
    assign bus.MemBusyM  = reset & bus.MemReqM & (state_q != ST_DONE);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32I core.
- Serves the Memory-stage load/store requests issued by the datapath: address from ALUResultM, store data from WriteDataM.
- Returns ReadDataM and inserts a configurable number of wait states.
- Drives a busy/stall signal into the hazard unit, which holds the pipeline (StallF/StallD, freezes M) until the access completes.
- Contains a word-organised RAM with byte/halfword lane handling per funct3.

Parameters:
- AW, 8, log2 of RAM depth in 32-bit words (256 words).
- WAIT_CYCLES, 2, extra wait cycles per access; legal 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemReqM  input  1  access request valid; held stable with all other M inputs while MemBusyM=1.
- MemWriteM  input  1  1=store, 0=load.
- funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  input  32  byte address.
- WriteDataM  input  32  store data, right-aligned.
- ReadDataM  output  32  load result, extended; registered.
- MemBusyM  output  1  stall request to the hazard unit.
- MisalignM  output  1  registered; 1 for the completing access if it was misaligned or used an illegal funct3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, ReadDataM=0, MisalignM=0.
  - MemBusyM forced 0.
  - RAM contents are not cleared.
  - Reset asserted mid-access aborts the access with no write.
- States: IDLE, WAIT, DONE. 4-bit counter cnt.
- IDLE:
  - MemReqM=0 -> stay.
  - MemReqM=1 and WAIT_CYCLES=0 -> perform access at this edge, go DONE.
  - Otherwise -> cnt<=WAIT_CYCLES-1, go WAIT.
- WAIT:
  - MemReqM=0 (flush) -> abort, no write, go IDLE.
  - cnt=0 -> perform access at this edge, go DONE.
  - Else cnt<=cnt-1.
- DONE: always go IDLE next edge. A request present in the following cycle is a new request.
- MemBusyM = MemReqM & (state!=DONE), combinational. Busy is high for exactly WAIT_CYCLES+1 cycles per access and low in the DONE cycle, when the pipeline advances.
- Address mapping:
  - Word index = ALUResultM[AW+1:2]; upper bits ignored, so addresses alias modulo 4·2^AW.
  - Byte offset = ALUResultM[1:0].
- Stores:
  - SB writes lane offset.
  - SH writes lanes {off+1,off}, off∈{0,2}.
  - SW writes all lanes, off=0.
  - Other lanes are unchanged (byte-enable write).
- Loads:
  - Selected byte/half is shifted to bit 0.
  - B/H sign-extend; BU/HU/W zero-extend.
  - Result is registered into ReadDataM at the access edge. ReadDataM holds its value until the next completed load.
  - Stores and aborted accesses do not change ReadDataM.
- Misalignment:
  - Misaligned means H/HU with off[0]=1, W with off≠0, or a store funct3 outside {000,001,010}, or a load funct3 outside the five codes above.
  - Misaligned store: no write.
  - Misaligned load: ReadDataM<=0.
  - In both cases MisalignM<=1 for that access; MisalignM<=0 on every correct access.
  - The access still takes the full latency.
- MisalignM is updated only at the access edge.
- A store followed by a load to the same address returns the new data (the accesses are sequential; no bypass needed).

Test Plan:
- Reset, then WAIT_CYCLES=2. SW 0xDEADBEEF @0x10, then LW @0x10 -> busy high exactly 3 cycles per access; ReadDataM=0xDEADBEEF in the DONE cycle; MisalignM=0.
- After the previous step, SB 0x80 @0x11, then LB @0x11 -> ReadDataM=0xFFFFFF80. LBU @0x11 -> 0x00000080. LW @0x10 -> 0xDEAD80EF.
- SH 0x1234 @0x22, then LHU @0x22 -> 0x00001234. LH @0x21 (misaligned) -> ReadDataM=0, MisalignM=1, no RAM change.
- Start LW; drop MemReqM in the second WAIT cycle -> state returns to IDLE, no write, ReadDataM unchanged, MemBusyM=0.
- WAIT_CYCLES=0 -> busy 1 cycle per access; back-to-back SW @0x0 then LW @0x400 (alias of 0x0 with AW=8) returns the stored word.
- Assert reset mid-WAIT of an SW -> outputs zero immediately; after release, LW of that address shows the old contents.
